wb_scheduler: RTL

// - Owns the single register-file write port and shares it between the execute path and the load-return path.
// - Execute path: ALU results and JAL/JALR return addresses. Load-return path: in-order, multi-cycle memory reads.
// - Keeps a per-register busy scoreboard for outstanding loads. Generates load-use and WAW hazard stalls for decode/execute.
// - Drives one registered write to the register file per cycle.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/wb_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared types and sizes for the write-back scheduler slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    typedef enum logic [1:0] {
        WB_ALU          = 2'd0,
        WB_MEM          = 2'd1,
        WB_PC_PLUS_FOUR = 2'd2
    } wb_src_t;

    localparam int REG_AW = 3;
    localparam int XLEN   = 16;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LD   = 2'd1,
        GNT_EX   = 2'd2
    } wb_grant_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO, read data shows the head entry combinationally.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Index wraps at DEPTH-1 so non-power-of-two depths work; top bit is the lap flag.
    function automatic logic [AW:0] f_next(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(DEPTH - 1)) begin
            return {~p[AW], {AW{1'b0}}};
        end
        return p + (AW + 1)'(1);
    endfunction

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/wb_scheduler.sv
// ============================================================================
// Module : wb_scheduler
// Brief  : Shares the register-file write port between execute results and
//          in-order load returns; tracks busy registers for hazard stalls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_scheduler #(
    parameter int MAX_LD = 2,
    parameter int XLEN   = 16,
    parameter int NREG   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      ex_valid_i,
    output logic                      ex_ready_o,
    input  logic [$clog2(NREG)-1:0]   ex_rd_i,
    input  riscv_pkg::wb_src_t        ex_sel_i,
    input  logic [XLEN-1:0]           ex_alu_i,
    input  logic [XLEN-1:0]           ex_ret_i,
    input  logic                      ld_valid_i,
    output logic                      ld_ready_o,
    input  logic [$clog2(NREG)-1:0]   ld_rd_i,
    input  logic                      rsp_valid_i,
    input  logic [XLEN-1:0]           rsp_data_i,
    input  logic [$clog2(NREG)-1:0]   rs1_i,
    input  logic [$clog2(NREG)-1:0]   rs2_i,
    output logic                      hazard_o,
    output logic                      rf_we_o,
    output logic [$clog2(NREG)-1:0]   rf_waddr_o,
    output logic [XLEN-1:0]           rf_wdata_o
);

    import riscv_pkg::*;

    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(MAX_LD + 1);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [CW-1:0]   r_outstanding;

    logic            w_tag_empty;
    logic            w_tag_full;
    logic [AW-1:0]   w_tag_q;
    logic            w_data_empty;
    logic            w_data_full;
    logic [XLEN-1:0] w_data_q;

    logic            w_ld_accept;
    logic            w_rsp_take;
    logic            w_ld_avail;
    logic            w_retire;
    logic            w_data_push;
    logic [XLEN-1:0] w_ld_data;
    logic            w_ex_free;
    wb_grant_t       w_grant;

    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [XLEN-1:0] w_wdata;

    // Responses with no outstanding tag are strays (e.g. after reset) and are dropped.
    assign w_rsp_take  = rsp_valid_i && !w_tag_empty && !w_data_full;
    // An arriving response bypasses an empty FIFO so it can retire this cycle.
    assign w_ld_avail  = !w_data_empty || w_rsp_take;
    assign w_ld_data   = w_data_empty ? rsp_data_i : w_data_q;
    assign w_data_push = w_rsp_take && !w_data_empty;

    assign w_ex_free   = ex_valid_i && !r_busy[ex_rd_i];
    assign ex_ready_o  = w_ex_free && !w_ld_avail;
    assign ld_ready_o  = (r_outstanding < CW'(MAX_LD)) && !w_tag_full && !r_busy[ld_rd_i];
    assign w_ld_accept = ld_valid_i && ld_ready_o;
    assign hazard_o    = r_busy[rs1_i] | r_busy[rs2_i];
    assign w_retire    = (w_grant == GNT_LD);

    sync_fifo #(.WIDTH(AW), .DEPTH(MAX_LD)) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_ld_accept),
        .i_data  (ld_rd_i),
        .i_pop   (w_retire),
        .o_data  (w_tag_q),
        .o_empty (w_tag_empty),
        .o_full  (w_tag_full)
    );

    sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_LD)) u_data_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_data_push),
        .i_data  (rsp_data_i),
        .i_pop   (w_retire),
        .o_data  (w_data_q),
        .o_empty (w_data_empty),
        .o_full  (w_data_full)
    );

    always_comb begin
        w_grant = GNT_NONE;
        if (w_ld_avail) begin
            w_grant = GNT_LD;
        end else if (w_ex_free) begin
            w_grant = GNT_EX;
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = rf_waddr_o;
        w_wdata = rf_wdata_o;
        case (w_grant)
            GNT_LD: begin
                w_we    = (w_tag_q != '0);
                w_waddr = w_tag_q;
                w_wdata = w_ld_data;
            end
            GNT_EX: begin
                w_waddr = ex_rd_i;
                case (ex_sel_i)
                    WB_ALU: begin
                        w_we    = (ex_rd_i != '0);
                        w_wdata = ex_alu_i;
                    end
                    WB_PC_PLUS_FOUR: begin
                        w_we    = (ex_rd_i != '0);
                        w_wdata = ex_ret_i;
                    end
                    default: w_wdata = '0;
                endcase
            end
            default: ;
        endcase
    end

    // Clear-before-set ordering is safe: issue to a retiring register is already blocked by busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_retire) w_busy_nxt[w_tag_q] = 1'b0;
        if (w_ld_accept && (ld_rd_i != '0)) w_busy_nxt[ld_rd_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy        <= '0;
            r_outstanding <= '0;
            rf_we_o       <= 1'b0;
            rf_waddr_o    <= '0;
            rf_wdata_o    <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            rf_we_o    <= w_we;
            rf_waddr_o <= w_waddr;
            rf_wdata_o <= w_wdata;
            case ({w_ld_accept, w_retire})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && (w_grant == GNT_EX)) begin
            a_ex_sel_legal: assert ((ex_sel_i == WB_ALU) || (ex_sel_i == WB_PC_PLUS_FOUR));
        end
    end

endmodule

`default_nettype wire
